led_pio_arbiter: RTL and testbench
==================================

LED_PIO_ARBITER -- requirements
Module: led_pio_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 14, LED data width matching the LED PIO out_port.
REQ-002 The block SHALL have parameter BLINK_DIV, default 25_000_000, clk cycles per blink half-period (legal range 2 to 2^32-1).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have ports a_valid, input, 1, and a_data, input, DATA_W: requester A write request and value.
REQ-006 The block SHALL have port a_ready, output, 1: A accepted, a single-cycle pulse.
REQ-007 The block SHALL have ports b_valid, b_data and b_ready: requester B, identical in meaning to A.
REQ-008 The block SHALL have port blink_mask, input, DATA_W: LED bits that blink; sampled live.
REQ-009 The block SHALL have ports m_address (output, 2), m_chipselect (output, 1), m_write_n (output, 1) and m_writedata (output, 32): the Avalon-MM master to the LED PIO s1 slave.
REQ-010 The block SHALL have port busy, output, 1: the FSM is not in IDLE.
REQ-011 The block SHALL have port led_shadow, output, DATA_W: the last accepted base value, before blinking is applied.

Function
REQ-012 The FSM SHALL have three states, IDLE, WRITE and TURN; transitions are IDLE->WRITE on a grant, WRITE->TURN always, and TURN->IDLE always.
REQ-013 In IDLE, a grant SHALL occur when tick_pend, a_valid or b_valid is high; tick_pend has the highest priority.
REQ-014 When A and B are both valid with no tick, round-robin SHALL apply: grant the requester not granted last, A first after reset.
REQ-015 On a requester grant, the granted ready SHALL pulse in that IDLE cycle; base <= granted data and the last-grant record updates. Ready is never asserted outside IDLE.
REQ-016 Requesters SHALL hold valid and data until ready; a valid dropped early is simply not serviced.
REQ-017 In WRITE, m_chipselect=1, m_write_n=0, m_address=0 and m_writedata = zero-extended (base & ~(blink_mask & {DATA_W{phase}})), for exactly one cycle; the PIO has no waitrequest.
REQ-018 In TURN and IDLE, m_chipselect=0, m_write_n=1 and m_writedata holds its last value.
REQ-019 The grant-to-write latency SHALL be 1 cycle; the minimum spacing between PIO writes SHALL be 3 cycles.
REQ-020 The blink counter SHALL count 0..BLINK_DIV-1 and wrap; at the wrap it toggles phase and sets tick_pend if blink_mask != 0.
REQ-021 tick_pend SHALL clear on its grant; a tick arriving while already pending merges into one; a tick in the same cycle as its own grant re-sets it.
REQ-022 A tick grant SHALL write the current base with the new phase and SHALL NOT change base or pulse any ready.
REQ-023 A blink_mask change SHALL take effect at the next write only; no write is generated by the change itself.

Reset
REQ-024 On reset, state, base, phase, counter, tick_pend and last-grant SHALL clear, and the next grant tie goes to A.
REQ-025 On reset, outputs SHALL be: a_ready=0, b_ready=0, m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, busy=0, led_shadow=0.
REQ-026 Reset asserted during WRITE SHALL deassert chipselect in the next cycle, with no retry and no ready pulse.

Structure
REQ-027 Package led_pio_pkg SHALL hold the state enum, LED_DATA_W=14 and PIO_DATA_ADDR=2'd0.
REQ-028 Sub-module led_blink_timer SHALL contain the counter, phase and wrap-pulse output; the arbiter holds tick_pend.

Verification
REQ-029 Bench (BLINK_DIV=8): A writes 14'h0155 -> a_ready 1 cycle, next cycle chipselect=1, write_n=0, writedata=32'h155, led_shadow=14'h0155.
REQ-030 Bench: A and B valid continuously with 14'h0001/14'h0002 -> grants A,B,A,B; writes spaced exactly 3 cycles.
REQ-031 Bench: base 14'h3FFF, blink_mask 14'h000F -> writes alternate 14'h3FF0 (phase 1) and 14'h3FFF every 8 cycles.
REQ-032 Bench: tick and a_valid in the same IDLE cycle -> tick written first, A granted 3 cycles later.
REQ-033 Bench: blink_mask=0 for 40 cycles -> no PIO writes.
REQ-034 Bench: reset during WRITE -> chipselect=0 next cycle, all outputs at reset values, no ready pulse.

Source files
------------

// File: rtl/led_pio_pkg.sv
// Shared types and constants for the LED PIO write arbiter.
package led_pio_pkg;

    localparam int         LED_DATA_W    = 14;
    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/led_blink_timer.sv
// Blink half-period timer: free-running 0..BLINK_DIV-1 counter, phase bit and
// a wrap strobe that is high during the last count of each half-period.
module led_blink_timer
    import led_pio_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic phase,
    output logic wrap
);

    localparam logic [31:0] TERM_CNT = 32'(BLINK_DIV - 1);

    logic [31:0] cnt;

    assign wrap = (cnt == TERM_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/led_pio_arbiter.sv
// Two-requester arbiter with blink overlay driving the LED PIO Avalon-MM slave.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | wait for tick_pend / a_valid / b_valid, grant one of them
//   ST_WRITE | single-cycle PIO write of base with blink mask applied
//   ST_TURN  | turnaround cycle, keeps PIO writes at least 3 cycles apart
module led_pio_arbiter
    import led_pio_pkg::*;
#(
    parameter int          DATA_W    = LED_DATA_W,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic [DATA_W-1:0] blink_mask,
    output logic [1:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [31:0]       m_writedata,
    output logic              busy,
    output logic [DATA_W-1:0] led_shadow
);

    arb_state_t        state;
    logic [DATA_W-1:0] base;
    logic              tick_pend;
    logic              prefer_b;
    logic              phase;
    logic              wrap;
    logic              idle;
    logic              grant_tick;
    logic              grant_a;
    logic              grant_b;
    logic [DATA_W-1:0] next_base;
    logic [DATA_W-1:0] blink_off;

    led_blink_timer #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink_timer (
        .clk   (clk),
        .reset (reset),
        .phase (phase),
        .wrap  (wrap)
    );

    // Grants are decided combinationally so ready pulses in the IDLE cycle itself.
    assign idle       = (state == ST_IDLE) && !reset;
    assign grant_tick = idle && tick_pend;
    assign grant_a    = idle && !tick_pend && a_valid && (!b_valid || !prefer_b);
    assign grant_b    = idle && !tick_pend && b_valid && !grant_a;

    assign a_ready    = grant_a;
    assign b_ready    = grant_b;
    assign busy       = (state != ST_IDLE);
    assign led_shadow = base;

    assign next_base  = grant_a ? a_data : (grant_b ? b_data : base);
    assign blink_off  = blink_mask & {DATA_W{phase}};

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            base         <= '0;
            tick_pend    <= 1'b0;
            prefer_b     <= 1'b0;
            m_address    <= PIO_DATA_ADDR;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_writedata  <= '0;
        end else begin
            // A wrap coinciding with a tick grant re-arms the tick.
            if (wrap && (blink_mask != '0)) begin
                tick_pend <= 1'b1;
            end else if (grant_tick) begin
                tick_pend <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (grant_tick || grant_a || grant_b) begin
                        state        <= ST_WRITE;
                        base         <= next_base;
                        m_address    <= PIO_DATA_ADDR;
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_writedata  <= 32'(next_base & ~blink_off);
                        if (grant_a) begin
                            prefer_b <= 1'b1;
                        end else if (grant_b) begin
                            prefer_b <= 1'b0;
                        end
                    end
                end
                ST_WRITE: begin
                    state        <= ST_TURN;
                    m_chipselect <= 1'b0;
                    m_write_n    <= 1'b1;
                end
                ST_TURN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state        <= ST_IDLE;
                    m_chipselect <= 1'b0;
                    m_write_n    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pio_arbiter.sv
// Self-checking bench for led_pio_arbiter: directed scenarios plus random
// traffic, all compared every cycle against a behavioural reference model.
module tb_led_pio_arbiter;

    localparam int DW  = 14;
    localparam int DIV = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_valid, b_valid;
    logic [DW-1:0] a_data, b_data, blink_mask;
    logic          a_ready, b_ready;
    logic [1:0]    m_address;
    logic          m_chipselect, m_write_n;
    logic [31:0]   m_writedata;
    logic          busy;
    logic [DW-1:0] led_shadow;

    always #5 clk = ~clk;

    led_pio_arbiter #(
        .DATA_W    (DW),
        .BLINK_DIV (DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .a_valid      (a_valid),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .blink_mask   (blink_mask),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .busy         (busy),
        .led_shadow   (led_shadow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: time since reset, cycles left until idle, pending tick.
    int            t        = 0;
    int            slot     = 0;
    bit            pend     = 0;
    bit            prefer_b = 0;
    logic [DW-1:0] base     = '0;
    logic [31:0]   wd       = '0;
    int            cyc      = 0;
    int            last_wr  = -100;
    bit            granted_a = 0;
    bit            granted_b = 0;

    typedef struct {
        int          c;
        logic [31:0] d;
    } wr_t;
    wr_t wlog[$];

    task automatic cycle();
        bit            ph, wrap, idle, gt, ga, gb;
        logic [DW-1:0] nb;
        @(negedge clk);
        ph   = ((t / DIV) % 2) == 1;
        wrap = (t % DIV) == DIV - 1;
        idle = (slot == 0);
        gt   = !reset && idle && pend;
        ga   = !reset && idle && !pend && a_valid && (!b_valid || !prefer_b);
        gb   = !reset && idle && !pend && b_valid && !ga;

        check("a_ready", 32'(a_ready), 32'(ga));
        check("b_ready", 32'(b_ready), 32'(gb));
        check("busy", 32'(busy), 32'(!idle));
        check("chipselect", 32'(m_chipselect), 32'(slot == 2));
        check("write_n", 32'(m_write_n), 32'(slot != 2));
        check("address", 32'(m_address), 32'd0);
        check("writedata", m_writedata, wd);
        check("led_shadow", 32'(led_shadow), 32'(base));

        if (m_chipselect && !m_write_n) begin
            check("write_spacing", 32'((cyc - last_wr) >= 3), 32'd1);
            last_wr = cyc;
            wlog.push_back('{cyc, m_writedata});
        end

        granted_a = ga;
        granted_b = gb;
        if (reset) begin
            t = 0; slot = 0; pend = 0; prefer_b = 0;
            base = '0; wd = '0; last_wr = -100;
        end else begin
            if (gt || ga || gb) begin
                nb   = gb ? b_data : (ga ? a_data : base);
                wd   = 32'(nb & ~(blink_mask & {DW{ph}}));
                base = nb;
                if (ga) prefer_b = 1;
                if (gb) prefer_b = 0;
                slot = 2;
            end else if (slot > 0) begin
                slot--;
            end
            if (wrap && blink_mask != '0) pend = 1;
            else if (gt) pend = 0;
            t++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        cycle();
        reset   = 1'b0;
        wlog.delete();
    endtask

    initial begin
        reset      = 1'b1;
        a_valid    = 1'b0;
        b_valid    = 1'b0;
        a_data     = '0;
        b_data     = '0;
        blink_mask = '0;
        repeat (2) @(posedge clk);
        #1;

        // Single A write with latency 1
        do_reset();
        a_valid = 1'b1;
        a_data  = 14'h0155;
        cycle();
        a_valid = 1'b0;
        repeat (4) cycle();
        check("s1_nwrites", 32'(wlog.size()), 32'd1);
        check("s1_data", wlog[0].d, 32'h155);
        check("s1_latency", 32'(wlog[0].c - (cyc - 5)), 32'd1);

        // Continuous A and B alternate, writes 3 cycles apart
        do_reset();
        a_valid = 1'b1; a_data = 14'h0001;
        b_valid = 1'b1; b_data = 14'h0002;
        repeat (12) cycle();
        a_valid = 1'b0; b_valid = 1'b0;
        check("s2_nwrites", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("s2_order", wlog[i].d, (i % 2 == 0) ? 32'h1 : 32'h2);
            if (i > 0) check("s2_gap", 32'(wlog[i].c - wlog[i-1].c), 32'd3);
        end

        // Blink overlay alternating every BLINK_DIV cycles
        do_reset();
        blink_mask = 14'h000F;
        a_valid = 1'b1; a_data = 14'h3FFF;
        for (int i = 0; i < 32; i++) begin
            cycle();
            if (granted_a) a_valid = 1'b0;
        end
        check("s3_nwrites", 32'(wlog.size()), 32'd4);
        check("s3_w0", wlog[0].d, 32'h3FFF);
        check("s3_w1", wlog[1].d, 32'h3FF0);
        check("s3_w2", wlog[2].d, 32'h3FFF);
        check("s3_w3", wlog[3].d, 32'h3FF0);
        check("s3_gap12", 32'(wlog[2].c - wlog[1].c), 32'd8);
        check("s3_gap23", 32'(wlog[3].c - wlog[2].c), 32'd8);

        // Tick and A in the same IDLE cycle: tick first, A three cycles later
        do_reset();
        blink_mask = 14'h0001;
        repeat (8) cycle();
        a_valid = 1'b1; a_data = 14'h2AAA;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (granted_a) a_valid = 1'b0;
        end
        check("s4_nwrites", 32'(wlog.size()), 32'd2);
        check("s4_tick_data", wlog[0].d, 32'h0);
        check("s4_a_data", wlog[1].d, 32'h2AAA);
        check("s4_gap", 32'(wlog[1].c - wlog[0].c), 32'd3);

        // No mask, no requests: no writes at all
        do_reset();
        blink_mask = '0;
        repeat (40) cycle();
        check("s5_nwrites", 32'(wlog.size()), 32'd0);

        // Reset during WRITE
        do_reset();
        a_valid = 1'b1; a_data = 14'h1234;
        cycle();
        a_valid = 1'b0;
        reset   = 1'b1;
        cycle();
        reset   = 1'b0;
        cycle();
        check("s6_cs_after_reset", 32'(m_chipselect), 32'd0);
        repeat (5) cycle();
        check("s6_nwrites", 32'(wlog.size()), 32'd1);
        check("s6_data", wlog[0].d, 32'h1234);

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 255) == 0);
            if (granted_a || !a_valid) begin
                a_valid = ($urandom_range(0, 2) == 0);
                a_data  = DW'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                a_valid = 1'b0;
            end
            if (granted_b || !b_valid) begin
                b_valid = ($urandom_range(0, 2) == 0);
                b_data  = DW'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                b_valid = 1'b0;
            end
            if ($urandom_range(0, 39) == 0)
                blink_mask = ($urandom_range(0, 1) == 0) ? '0 : DW'($urandom);
            cycle();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
